// File: rtl/pfs_fetch_arb.sv
// Packet-fetch arbiter: round-robin port pick, UC/MC alternation,
// per-port fetch credits and PFC pause masking, registered grant.
module pfs_fetch_arb #(
  parameter  int N_PORTS = 4,
  parameter  int CREDITS = 8,
  localparam int PW      = $clog2(N_PORTS),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [N_PORTS-1:0] uc_req_valid,
  input  logic [N_PORTS-1:0] mc_req_valid,
  input  logic [N_PORTS-1:0] pfc_xoff,
  input  logic               crd_ret_valid,
  input  logic [PW-1:0]      crd_ret_port,
  output logic               gnt_valid,
  output logic [PW-1:0]      gnt_port,
  output logic               gnt_mc,
  output logic [N_PORTS-1:0] crd_zero,
  output logic               crd_err
);

  logic [PW-1:0]      r_rr_ptr;
  logic [N_PORTS-1:0] r_pref;
  logic [CW-1:0]      r_crd [N_PORTS];
  logic               r_gnt_valid;
  logic [PW-1:0]      r_gnt_port;
  logic               r_gnt_mc;
  logic [N_PORTS-1:0] r_crd_zero;
  logic               r_crd_err;

  logic [N_PORTS-1:0] w_uc_elig;
  logic [N_PORTS-1:0] w_mc_elig;
  logic [N_PORTS-1:0] w_elig;
  logic               w_found;
  logic [PW-1:0]      w_sel;
  logic               w_sel_mc;
  logic [PW-1:0]      w_rr_nxt;
  logic [N_PORTS-1:0] w_dec;
  logic [N_PORTS-1:0] w_inc;
  logic [N_PORTS-1:0] w_ovf;
  logic [CW-1:0]      w_crd_nxt [N_PORTS];

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] base,
    input int unsigned   off
  );
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_PORTS) s = s - N_PORTS;
    return PW'(s);
  endfunction

  // last cycle's grant masks that (port, class) from winning again
  always_comb begin
    w_uc_elig = '0;
    w_mc_elig = '0;
    w_elig    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_uc_elig[p] = uc_req_valid[p] &
        ~(r_gnt_valid & (r_gnt_port == PW'(p)) & ~r_gnt_mc);
      w_mc_elig[p] = mc_req_valid[p] &
        ~(r_gnt_valid & (r_gnt_port == PW'(p)) & r_gnt_mc);
      w_elig[p] = (w_uc_elig[p] | w_mc_elig[p]) &
        ~pfc_xoff[p] & (r_crd[p] != '0);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!w_found && w_elig[wrap_add(r_rr_ptr, i)]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_rr_ptr, i);
      end
    end
  end

  always_comb begin
    w_sel_mc = 1'b0;
    if (w_uc_elig[w_sel] && w_mc_elig[w_sel])
      w_sel_mc = r_pref[w_sel];
    else
      w_sel_mc = w_mc_elig[w_sel];
  end

  assign w_rr_nxt = (w_sel == PW'(N_PORTS - 1)) ?
                    '0 : w_sel + PW'(1);

  always_comb begin
    w_dec = '0;
    w_inc = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_dec[p] = w_found & (w_sel == PW'(p));
      w_inc[p] = crd_ret_valid & (crd_ret_port == PW'(p));
    end
  end

  // simultaneous grant and return cancel out
  always_comb begin
    w_ovf = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_crd_nxt[p] = r_crd[p];
      case ({w_dec[p], w_inc[p]})
        2'b10: w_crd_nxt[p] = r_crd[p] - CW'(1);
        2'b01: begin
          if (r_crd[p] == CW'(CREDITS))
            w_ovf[p] = 1'b1;
          else
            w_crd_nxt[p] = r_crd[p] + CW'(1);
        end
        default: w_crd_nxt[p] = r_crd[p];
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rr_ptr    <= '0;
      r_pref      <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_port  <= '0;
      r_gnt_mc    <= 1'b0;
      r_crd_zero  <= '0;
      r_crd_err   <= 1'b0;
      for (int p = 0; p < N_PORTS; p++)
        r_crd[p] <= CW'(CREDITS);
    end else begin
      r_gnt_valid <= w_found;
      if (w_found) begin
        r_gnt_port     <= w_sel;
        r_gnt_mc       <= w_sel_mc;
        r_pref[w_sel]  <= ~w_sel_mc;
        r_rr_ptr       <= w_rr_nxt;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        r_crd[p]      <= w_crd_nxt[p];
        r_crd_zero[p] <= (w_crd_nxt[p] == '0);
      end
      if (|w_ovf)
        r_crd_err <= 1'b1;
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_port  = r_gnt_port;
  assign gnt_mc    = r_gnt_mc;
  assign crd_zero  = r_crd_zero;
  assign crd_err   = r_crd_err;

endmodule

// File: tb/tb_pfs_fetch_arb.sv
// Scoreboard bench for pfs_fetch_arb: reference model pushes expected
// grants per arbitration cycle; registered outputs are popped and compared.
module tb_pfs_fetch_arb;

  localparam int N  = 4;
  localparam int C  = 8;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [N-1:0]  uc = '0;
  logic [N-1:0]  mc = '0;
  logic [N-1:0]  xoff = '0;
  logic          ret_v = 1'b0;
  logic [PW-1:0] ret_port = '0;
  logic          gnt_valid;
  logic [PW-1:0] gnt_port;
  logic          gnt_mc;
  logic [N-1:0]  crd_zero;
  logic          crd_err;

  pfs_fetch_arb #(.N_PORTS(N), .CREDITS(C)) dut (
    .clk          (clk),
    .arst         (arst),
    .uc_req_valid (uc),
    .mc_req_valid (mc),
    .pfc_xoff     (xoff),
    .crd_ret_valid(ret_v),
    .crd_ret_port (ret_port),
    .gnt_valid    (gnt_valid),
    .gnt_port     (gnt_port),
    .gnt_mc       (gnt_mc),
    .crd_zero     (crd_zero),
    .crd_err      (crd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    int         port;
    bit         mc;
    logic [N-1:0] zero;
    bit         err;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  int m_crd [N];
  bit m_pref [N];
  int m_rr;
  bit m_v;
  int m_port;
  bit m_mc;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_crd[p]  = C;
      m_pref[p] = 1'b0;
    end
    m_rr = 0; m_v = 0; m_port = 0; m_mc = 0; m_err = 0;
  endtask

  task automatic model_eval();
    exp_t e;
    bit   found, ue, me, gmc, dec, inc;
    int   gp, p;
    found = 0; gp = 0; gmc = 0;
    for (int k = 0; k < N; k++) begin
      p  = (m_rr + k) % N;
      ue = uc[p] && !(m_v && m_port == p && !m_mc);
      me = mc[p] && !(m_v && m_port == p && m_mc);
      if (!found && (ue || me) && !xoff[p] && m_crd[p] > 0) begin
        found = 1;
        gp    = p;
        gmc   = (ue && me) ? m_pref[p] : me;
      end
    end
    for (int q = 0; q < N; q++) begin
      dec = found && gp == q;
      inc = ret_v && int'(ret_port) == q;
      if (dec && !inc) m_crd[q]--;
      else if (inc && !dec) begin
        if (m_crd[q] == C) m_err = 1;
        else m_crd[q]++;
      end
    end
    if (found) begin
      m_pref[gp] = !gmc;
      m_rr       = (gp + 1) % N;
    end
    m_v = found; m_port = gp; m_mc = gmc;
    e.v = found; e.port = gp; e.mc = gmc; e.err = m_err;
    for (int q = 0; q < N; q++) e.zero[q] = (m_crd[q] == 0);
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_eval();
    @(posedge clk);
    #1;
    chk("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("gnt_valid", gnt_valid, e.v);
      if (e.v) begin
        chk("gnt_port", gnt_port, e.port);
        chk("gnt_mc", gnt_mc, e.mc);
      end
      chk("crd_zero", crd_zero, e.zero);
      chk("crd_err", crd_err, e.err);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_crd_zero", crd_zero, 0);
    chk("rst_crd_err", crd_err, 0);
    uc = '0; mc = '0; xoff = '0; ret_v = 0; ret_port = '0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    sbq.delete();
  endtask

  int ng, ng1;
  bit seen;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_gnt_port", gnt_port, 0);
    chk("rst_gnt_mc", gnt_mc, 0);

    // idle
    for (int i = 0; i < 20; i++) step();
    chk("idle_zero", crd_zero, 0);

    // round robin
    do_reset();
    uc = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", gnt_valid, 1);
      chk("rr_port", gnt_port, i % 4);
      chk("rr_mc", gnt_mc, 0);
    end

    // uc/mc alternation on port 2
    do_reset();
    uc = 4'b0100; mc = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_valid", gnt_valid, 1);
      chk("alt_port", gnt_port, 2);
      chk("alt_mc", gnt_mc, i % 2);
    end

    // credit exhaustion and refill
    do_reset();
    uc = 4'b0001;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_valid) ng++;
    end
    chk("exh_grants", ng, 8);
    chk("exh_zero", crd_zero[0], 1);
    ret_v = 1; ret_port = 0;
    step();
    chk("refill_zero", crd_zero[0], 0);
    chk("refill_nognt", gnt_valid, 0);
    ret_v = 0;
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gnt_valid) ng++;
    end
    chk("refill_grants", ng, 1);
    chk("refill_zero2", crd_zero[0], 1);
    ret_v = 1;
    step();
    step();
    chk("same_cyc_gnt", gnt_valid, 1);
    chk("same_cyc_zero", crd_zero[0], 0);
    ret_v = 0;
    ng = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (gnt_valid) ng++;
    end
    chk("same_cyc_grants", ng, 1);
    chk("same_cyc_zero2", crd_zero[0], 1);

    // pfc pause
    do_reset();
    uc = 4'b0011; xoff = 4'b0010;
    ng = 0; ng1 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt_valid && gnt_port == 0) ng++;
      if (gnt_valid && gnt_port == 1) ng1++;
    end
    chk("pfc_p1_grants", ng1, 0);
    chk("pfc_p0_grants", ng, 5);
    xoff = '0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (gnt_valid && gnt_port == 1) seen = 1;
    end
    chk("pfc_release", seen, 1);

    // credit overflow
    do_reset();
    ret_v = 1; ret_port = 3;
    step();
    chk("ovf_err", crd_err, 1);
    ret_v = 0;
    uc = 4'b1000;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_valid) ng++;
    end
    chk("ovf_grants", ng, 8);
    chk("ovf_zero", crd_zero[3], 1);
    chk("ovf_sticky", crd_err, 1);

    // random traffic, then reset mid-operation
    do_reset();
    chk("ovf_cleared", crd_err, 0);
    for (int i = 0; i < 400; i++) begin
      uc = N'($urandom);
      mc = N'($urandom);
      for (int p = 0; p < N; p++) xoff[p] = ($urandom_range(0, 4) == 0);
      ret_v    = ($urandom_range(0, 2) == 0);
      ret_port = PW'($urandom);
      step();
    end
    uc = 4'b1111; mc = 4'b1111; xoff = '0; ret_v = 0;
    step();
    do_reset();
    for (int i = 0; i < 4; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
